// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL reset / lock qualification / domain reset release sequencer.
// Runs entirely on refclk; pll_locked is asynchronous and passes through a synchronizer.
// Optional feature macro: PLL_TIMEOUT_RETRY_EN (WAIT_LOCK timeout re-pulses the PLL reset).
// Ports:
//   refclk        reference clock, rising edge
//   rst_n         asynchronous active-low reset
//   pll_locked    PLL lock flag (asynchronous)
//   pll_rst       PLL reset, active high
//   rst_out_n     NUM_RESETS domain resets, active low, released index 0 first
//   all_ready     high only in RUN
//   lock_timeout  sticky WAIT_LOCK timeout flag, cleared on first synced lock
//   lock_loss_cnt saturating count of lock losses seen in RELEASE/RUN
//   state_o       current FSM state encoding
module pll_reset_sequencer #(
   parameter int unsigned NUM_RESETS         = 4,
   parameter int unsigned SYNC_STAGES        = 2,
   parameter int unsigned PLL_RST_CYCLES     = 16,
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned RELEASE_GAP        = 8,
   parameter int unsigned LOCK_TIMEOUT       = 65536,
   parameter int unsigned LOSS_CNT_W         = 8
) (
   input  logic                  refclk,
   input  logic                  rst_n,
   input  logic                  pll_locked,
   output logic                  pll_rst,
   output logic [NUM_RESETS-1:0] rst_out_n,
   output logic                  all_ready,
   output logic                  lock_timeout,
   output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
   output logic [2:0]            state_o
);

   // One shared counter serves every timed state; size it for the longest interval.
   localparam int unsigned MAX_A   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
   localparam int unsigned MAX_B   = (LOCK_TIMEOUT > RELEASE_GAP) ? LOCK_TIMEOUT : RELEASE_GAP;
   localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] PRST_LAST   = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(RELEASE_GAP - 1);

   typedef enum logic [2:0] {
      ST_PLL_RST   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RELEASE   = 3'd3,
      ST_RUN       = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [SYNC_STAGES-1:0]  sync_q, sync_d;
   logic                    pll_rst_q, pll_rst_d;
   logic [NUM_RESETS-1:0]   rst_out_n_q, rst_out_n_d;
   logic                    all_ready_q, all_ready_d;
   logic                    lock_timeout_q, lock_timeout_d;
   logic [LOSS_CNT_W-1:0]   loss_cnt_q, loss_cnt_d;
   logic                    lk_c;

   assign lk_c = sync_q[SYNC_STAGES-1];

   // State and output registers
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_PLL_RST;
         cnt_q          <= '0;
         sync_q         <= '0;
         pll_rst_q      <= 1'b1;
         rst_out_n_q    <= '0;
         all_ready_q    <= 1'b0;
         lock_timeout_q <= 1'b0;
         loss_cnt_q     <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         sync_q         <= sync_d;
         pll_rst_q      <= pll_rst_d;
         rst_out_n_q    <= rst_out_n_d;
         all_ready_q    <= all_ready_d;
         lock_timeout_q <= lock_timeout_d;
         loss_cnt_q     <= loss_cnt_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      sync_d         = {sync_q[SYNC_STAGES-2:0], pll_locked};
      pll_rst_d      = 1'b0;
      rst_out_n_d    = rst_out_n_q;
      all_ready_d    = all_ready_q;
      lock_timeout_d = lock_timeout_q;
      loss_cnt_d     = loss_cnt_q;

      case (state_q)
         ST_PLL_RST: begin
            rst_out_n_d = '0;
            all_ready_d = 1'b0;
            if (cnt_q == PRST_LAST) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
            end else begin
               pll_rst_d = 1'b1;
               cnt_d     = cnt_q + CNT_W'(1);
            end
         end

         ST_WAIT_LOCK: begin
            if (lk_c) begin
               state_d        = ST_STABLE;
               cnt_d          = '0;
               lock_timeout_d = 1'b0;
            end else if (cnt_q == TMO_LAST) begin
               lock_timeout_d = 1'b1;
`ifdef PLL_TIMEOUT_RETRY_EN
               state_d   = ST_PLL_RST;
               cnt_d     = '0;
               pll_rst_d = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_STABLE: begin
            if (!lk_c) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == STABLE_LAST) begin
               state_d     = ST_RELEASE;
               cnt_d       = '0;
               rst_out_n_d = NUM_RESETS'(1);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_RELEASE, ST_RUN: begin
            if (!lk_c) begin
               // Lock loss: drop every domain together, no PLL reset pulse.
               state_d     = ST_WAIT_LOCK;
               cnt_d       = '0;
               rst_out_n_d = '0;
               all_ready_d = 1'b0;
               if (loss_cnt_q != '1) begin
                  loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
               end
            end else if (state_q == ST_RELEASE) begin
               if (rst_out_n_q[NUM_RESETS-1]) begin
                  state_d     = ST_RUN;
                  cnt_d       = '0;
                  all_ready_d = 1'b1;
               end else if (cnt_q == GAP_LAST) begin
                  // Release the next domain by shifting a one into the mask.
                  rst_out_n_d = (rst_out_n_q << 1) | NUM_RESETS'(1);
                  cnt_d       = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         default: begin
            state_d     = ST_PLL_RST;
            cnt_d       = '0;
            pll_rst_d   = 1'b1;
            rst_out_n_d = '0;
            all_ready_d = 1'b0;
         end
      endcase
   end

   assign pll_rst       = pll_rst_q;
   assign rst_out_n     = rst_out_n_q;
   assign all_ready     = all_ready_q;
   assign lock_timeout  = lock_timeout_q;
   assign lock_loss_cnt = loss_cnt_q;
   assign state_o       = state_q;

endmodule
